// File: rtl/drum_loop_recorder_if.sv
// Control, pad and status bundle between the key-state storage and the drum loop recorder.
interface drum_loop_recorder_if #(
  parameter int unsigned NUM_PADS = 8,
  parameter int unsigned DEPTH    = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                tick;
  logic                rec_toggle;
  logic                stop_all;
  logic [NUM_PADS-1:0] pad_level;
  logic [NUM_PADS-1:0] pad_pulse;
  logic                recording;
  logic                playing;
  logic [CNT_W-1:0]    event_count;
  logic                overflow;

  modport master (
    output tick, rec_toggle, stop_all, pad_level,
    input  pad_pulse, recording, playing, event_count, overflow
  );

  modport slave (
    input  tick, rec_toggle, stop_all, pad_level,
    output pad_pulse, recording, playing, event_count, overflow
  );
endinterface

// File: rtl/drum_loop_recorder.sv
// Drum-mode looper: records timestamped pad rising edges, then replays them
// as an endless loop of one-cycle pad pulses.
module drum_loop_recorder #(
  parameter int unsigned NUM_PADS = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned TS_WIDTH = 16
) (
  input logic                 CLOCK_50,
  input logic                 resetn,
  drum_loop_recorder_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = TS_WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [NUM_PADS-1:0] pads;
  } event_t;

  event_t mem [DEPTH];

  logic [1:0]          state, state_nxt;
  logic [TS_WIDTH-1:0] timer, timer_nxt;
  logic [CNT_W-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [LEN_W-1:0]    loop_len, loop_len_nxt;
  logic [NUM_PADS-1:0] pad_prev, pulse, pulse_nxt, edges;
  logic                overflow, overflow_nxt;
  logic                recording, playing;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  event_t              wr_data, rd_data;
  logic                rec_stop, fire, wrap;

  assign edges   = bus.pad_level & ~pad_prev;
  assign rd_data = mem[idx[IDX_W-1:0]];
  // A tick at the last representable timestamp ends the take exactly like rec_toggle.
  assign rec_stop = bus.rec_toggle || (bus.tick && (timer == {TS_WIDTH{1'b1}}));
  assign fire     = (idx < count) && (rd_data.ts == timer);
  assign wrap     = ((LEN_W'(timer) + LEN_W'(1)) == loop_len);

  // Next-state and datapath decode
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    idx_nxt      = idx;
    count_nxt    = count;
    loop_len_nxt = loop_len;
    overflow_nxt = overflow;
    pulse_nxt    = '0;
    wr_en        = 1'b0;
    wr_addr      = count[IDX_W-1:0];
    wr_data.ts   = timer;
    wr_data.pads = edges;

    if (bus.stop_all) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rec_toggle) begin
            state_nxt    = S_REC;
            timer_nxt    = '0;
            count_nxt    = '0;
            overflow_nxt = 1'b0;
          end
        end
        S_REC: begin
          if (bus.tick) timer_nxt = timer + TS_WIDTH'(1);
          if (edges != '0) begin
            if (count == CNT_W'(DEPTH)) begin
              overflow_nxt = 1'b1;
            end else begin
              wr_en     = 1'b1;
              count_nxt = count + CNT_W'(1);
            end
          end
          // The edge of the stopping cycle is already folded into count_nxt.
          if (rec_stop) begin
            loop_len_nxt = LEN_W'(timer) + LEN_W'(1);
            timer_nxt    = '0;
            idx_nxt      = '0;
            state_nxt    = (count_nxt == '0) ? S_IDLE : S_PLAY;
          end
        end
        S_PLAY: begin
          if (bus.rec_toggle) begin
            state_nxt    = S_REC;
            timer_nxt    = '0;
            count_nxt    = '0;
            overflow_nxt = 1'b0;
          end else begin
            if (fire) begin
              pulse_nxt = rd_data.pads;
              idx_nxt   = idx + CNT_W'(1);
            end
            if (bus.tick) begin
              if (wrap) begin
                timer_nxt = '0;
                idx_nxt   = '0;
              end else begin
                timer_nxt = timer + TS_WIDTH'(1);
              end
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State and status registers
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= S_IDLE;
      timer     <= '0;
      idx       <= '0;
      count     <= '0;
      loop_len  <= '0;
      overflow  <= 1'b0;
      pad_prev  <= '0;
      pulse     <= '0;
      recording <= 1'b0;
      playing   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      count     <= count_nxt;
      loop_len  <= loop_len_nxt;
      overflow  <= overflow_nxt;
      pad_prev  <= bus.pad_level;
      pulse     <= pulse_nxt;
      recording <= (state_nxt == S_REC);
      playing   <= (state_nxt == S_PLAY);
    end
  end

  // Event buffer; contents are don't-care after reset
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign bus.pad_pulse   = pulse;
  assign bus.recording   = recording;
  assign bus.playing     = playing;
  assign bus.event_count = count;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_drum_loop_recorder.sv
// Directed bench for drum_loop_recorder: default instance plus a 4-bit-timestamp instance.
module tb_drum_loop_recorder;
  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  drum_loop_recorder_if #(.NUM_PADS(8), .DEPTH(32)) bus_a ();
  drum_loop_recorder_if #(.NUM_PADS(8), .DEPTH(32)) bus_b ();

  drum_loop_recorder #(.NUM_PADS(8), .DEPTH(32), .TS_WIDTH(16)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .bus(bus_a)
  );
  drum_loop_recorder #(.NUM_PADS(8), .DEPTH(32), .TS_WIDTH(4)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .bus(bus_b)
  );

  task automatic cyc(input logic t, input logic rt, input logic sa, input logic [7:0] p);
    bus_a.tick = t; bus_a.rec_toggle = rt; bus_a.stop_all = sa; bus_a.pad_level = p;
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic t, input logic rt, input logic sa, input logic [7:0] p);
    bus_b.tick = t; bus_b.rec_toggle = rt; bus_b.stop_all = sa; bus_b.pad_level = p;
    @(posedge clk); #1;
  endtask

  task automatic group(input logic [7:0] p);
    cyc(1'b0, 1'b0, 1'b0, p);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus_b.tick = 1'b0; bus_b.rec_toggle = 1'b0; bus_b.stop_all = 1'b0; bus_b.pad_level = 8'h00;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    resetn = 1'b1;
    tests++; if (bus_a.pad_pulse !== 8'h00) begin fails++; $display("FAIL reset_pulse: got %h expected 00", bus_a.pad_pulse); end
    tests++; if (bus_a.recording !== 1'b0 || bus_a.playing !== 1'b0) begin fails++; $display("FAIL reset_flags: got rec=%b play=%b expected 0 0", bus_a.recording, bus_a.playing); end
    tests++; if (bus_a.event_count !== 6'd0 || bus_a.overflow !== 1'b0) begin fails++; $display("FAIL reset_count: got cnt=%0d ovf=%b expected 0 0", bus_a.event_count, bus_a.overflow); end
    tests++; if (bus_b.playing !== 1'b0 || bus_b.event_count !== 6'd0) begin fails++; $display("FAIL reset_b: got play=%b cnt=%0d expected 0 0", bus_b.playing, bus_b.event_count); end
  endtask

  task automatic test_basic_loop();
    logic [7:0] exp;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (bus_a.recording !== 1'b1 || bus_a.event_count !== 6'd0) begin fails++; $display("FAIL basic_rec_entry: got rec=%b cnt=%0d expected 1 0", bus_a.recording, bus_a.event_count); end
    group(8'h00); group(8'h00); group(8'h01); group(8'h00);
    group(8'h00); group(8'h02); group(8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (bus_a.playing !== 1'b1 || bus_a.recording !== 1'b0) begin fails++; $display("FAIL basic_play_entry: got play=%b rec=%b expected 1 0", bus_a.playing, bus_a.recording); end
    tests++; if (bus_a.event_count !== 6'd2) begin fails++; $display("FAIL basic_count: got %0d expected 2", bus_a.event_count); end
    for (int c = 0; c < 96; c++) begin
      cyc((c % 4) == 3, 1'b0, 1'b0, 8'h00);
      exp = ((c % 32) == 8) ? 8'h01 : (((c % 32) == 20) ? 8'h02 : 8'h00);
      tests++; if (bus_a.pad_pulse !== exp) begin fails++; $display("FAIL basic_pulse c=%0d: got %h expected %h", c, bus_a.pad_pulse, exp); end
    end
  endtask

  task automatic test_reset_mid_play();
    resetn = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    resetn = 1'b1;
    tests++; if (bus_a.playing !== 1'b0 || bus_a.pad_pulse !== 8'h00) begin fails++; $display("FAIL midplay_reset: got play=%b pulse=%h expected 0 00", bus_a.playing, bus_a.pad_pulse); end
    tests++; if (bus_a.event_count !== 6'd0 || bus_a.overflow !== 1'b0) begin fails++; $display("FAIL midplay_reset_cnt: got cnt=%0d ovf=%b expected 0 0", bus_a.event_count, bus_a.overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_p [8];
    logic       tk [8];
    exp_p = '{8'h05, 8'h02, 8'h00, 8'h08, 8'h00, 8'h05, 8'h02, 8'h00};
    tk    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h05);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h08);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (bus_a.event_count !== 6'd3 || bus_a.playing !== 1'b1) begin fails++; $display("FAIL simul_entry: got cnt=%0d play=%b expected 3 1", bus_a.event_count, bus_a.playing); end
    for (int c = 0; c < 8; c++) begin
      cyc(tk[c], 1'b0, 1'b0, 8'h00);
      tests++; if (bus_a.pad_pulse !== exp_p[c]) begin fails++; $display("FAIL simul_pulse c=%0d: got %h expected %h", c, bus_a.pad_pulse, exp_p[c]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 33; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(1 << (i % 8)));
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end
    tests++; if (bus_a.event_count !== 6'd32 || bus_a.overflow !== 1'b1) begin fails++; $display("FAIL ovf_rec: got cnt=%0d ovf=%b expected 32 1", bus_a.event_count, bus_a.overflow); end
    tests++; if (bus_a.recording !== 1'b1) begin fails++; $display("FAIL ovf_still_rec: got %b expected 1", bus_a.recording); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (bus_a.playing !== 1'b1 || bus_a.overflow !== 1'b1 || bus_a.event_count !== 6'd32) begin fails++; $display("FAIL ovf_play: got play=%b ovf=%b cnt=%0d expected 1 1 32", bus_a.playing, bus_a.overflow, bus_a.event_count); end
    for (int c = 0; c < 36; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      if (c < 32)       exp = 8'(1 << (c % 8));
      else if (c < 34)  exp = 8'h00;
      else              exp = 8'(1 << (c - 34));
      tests++; if (bus_a.pad_pulse !== exp) begin fails++; $display("FAIL ovf_pulse c=%0d: got %h expected %h", c, bus_a.pad_pulse, exp); end
    end
    // Re-record from PLAY on a cycle that would otherwise fire event 2.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (bus_a.recording !== 1'b1 || bus_a.playing !== 1'b0) begin fails++; $display("FAIL rerec_flags: got rec=%b play=%b expected 1 0", bus_a.recording, bus_a.playing); end
    tests++; if (bus_a.event_count !== 6'd0 || bus_a.overflow !== 1'b0 || bus_a.pad_pulse !== 8'h00) begin fails++; $display("FAIL rerec_clear: got cnt=%0d ovf=%b pulse=%h expected 0 0 00", bus_a.event_count, bus_a.overflow, bus_a.pad_pulse); end
  endtask

  task automatic test_control();
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 8'h01);
    cyc(1'b0, 1'b1, 1'b0, 8'h01);
    tests++; if (bus_a.recording !== 1'b0 || bus_a.playing !== 1'b0 || bus_a.event_count !== 6'd0) begin fails++; $display("FAIL empty_stop: got rec=%b play=%b cnt=%0d expected 0 0 0", bus_a.recording, bus_a.playing, bus_a.event_count); end
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    tests++; if (bus_a.recording !== 1'b0) begin fails++; $display("FAIL idle_priority: got rec=%b expected 0", bus_a.recording); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h04);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    tests++; if (bus_a.recording !== 1'b0 || bus_a.playing !== 1'b0 || bus_a.event_count !== 6'd1) begin fails++; $display("FAIL rec_priority: got rec=%b play=%b cnt=%0d expected 0 0 1", bus_a.recording, bus_a.playing, bus_a.event_count); end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h20);
    tests++; if (bus_a.playing !== 1'b1 || bus_a.event_count !== 6'd1) begin fails++; $display("FAIL stop_edge_kept: got play=%b cnt=%0d expected 1 1", bus_a.playing, bus_a.event_count); end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if (bus_a.pad_pulse !== 8'h20) begin fails++; $display("FAIL len1_pulse: got %h expected 20", bus_a.pad_pulse); end
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    tests++; if (bus_a.pad_pulse !== 8'h00 || bus_a.playing !== 1'b0 || bus_a.event_count !== 6'd1) begin fails++; $display("FAIL play_stop_all: got pulse=%h play=%b cnt=%0d expected 00 0 1", bus_a.pad_pulse, bus_a.playing, bus_a.event_count); end
  endtask

  task automatic test_saturation();
    logic [7:0] exp;
    do_reset();
    cyc_b(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      cyc_b(1'b1, 1'b0, 1'b0, (k == 0) ? 8'h01 : 8'h00);
      if (k == 14) begin
        tests++; if (bus_b.recording !== 1'b1) begin fails++; $display("FAIL sat_pre: got rec=%b expected 1", bus_b.recording); end
      end
    end
    tests++; if (bus_b.playing !== 1'b1 || bus_b.recording !== 1'b0 || bus_b.event_count !== 6'd1) begin fails++; $display("FAIL sat_auto_stop: got play=%b rec=%b cnt=%0d expected 1 0 1", bus_b.playing, bus_b.recording, bus_b.event_count); end
    for (int c = 0; c < 17; c++) begin
      cyc_b(1'b1, 1'b0, 1'b0, 8'h00);
      exp = (c == 0 || c == 16) ? 8'h01 : 8'h00;
      tests++; if (bus_b.pad_pulse !== exp) begin fails++; $display("FAIL sat_pulse c=%0d: got %h expected %h", c, bus_b.pad_pulse, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_reset_mid_play();
    test_simultaneous();
    test_overflow();
    test_control();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/drum_loop_recorder.md
Name: drum_loop_recorder

Overview:
- Drum-mode note recorder/looper. Sits directly downstream of the key-state storage (PS/2 decoded pad levels plus spacebar) and upstream of the drum sound/VGA note display stages.
- Captures timestamped pad presses while recording, then replays them as an endless loop of one-cycle pad pulses.
- Replaces the ad-hoc start/stop-recording substate logic inside the drums controller.

Parameters:
- NUM_PADS, 8, number of drum pad inputs (one bit per mapped key, e.g. F, G, ...).
- DEPTH, 32, event buffer entries (power of two).
- TS_WIDTH, 16, timestamp/timer width in ticks.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- tick  in  1  timebase strobe, one cycle wide; the timer advances once per tick.
- rec_toggle  in  1  one-cycle pulse from spacebar edge; start/stop control.
- stop_all  in  1  one-cycle pulse; abort to IDLE from any state.
- pad_level  in  NUM_PADS  live key-held levels from key-state storage.
- pad_pulse  out  NUM_PADS  registered one-cycle playback strobes.
- recording  out  1  high in REC.
- playing  out  1  high in PLAY.
- event_count  out  $clog2(DEPTH)+1  events stored.
- overflow  out  1  sticky: an event was dropped (buffer full).

Behaviour:
- Reset (resetn=0 at clock edge): state=IDLE; timer, idx, event_count, loop_len, pad_prev, pad_pulse all 0; recording=playing=overflow=0. Buffer contents are don't-care. Reset wins over every other input, including mid-REC or mid-PLAY.
- Edge detect: pad_prev <= pad_level every cycle in every state. edges = pad_level & ~pad_prev.
- IDLE:
  - On rec_toggle: go to REC. Clear timer, event_count and overflow.
  - Edges in IDLE are ignored, including an edge coincident with rec_toggle.
- REC:
  - On tick, timer++.
  - If edges != 0 in a cycle: store {timer, edges} at entry event_count and increment event_count.
  - Several pads rising in the same cycle form one event.
  - The stored timestamp is the pre-increment timer when tick and an edge coincide.
  - If event_count == DEPTH: drop the event and set overflow=1.
  - On rec_toggle: the current-cycle edge is still stored. Set loop_len = timer + 1 (tick-adjusted the same way).
    - If the resulting count is 0, go to IDLE.
    - Otherwise go to PLAY with timer=0, idx=0.
  - Timer saturation: if a tick arrives with timer == 2^TS_WIDTH-1, behave exactly as rec_toggle that cycle (auto-stop).
- PLAY (loop):
  - Each cycle, if idx < event_count and ts[idx] == timer: pad_pulse <= pads[idx] on the next edge, and idx++. Otherwise pad_pulse <= 0.
  - Events sharing a timestamp fire on consecutive cycles, one per cycle.
  - On tick: if timer + 1 == loop_len, set timer=0 and idx=0 (wrap); else timer++. Events not yet emitted at wrap are skipped for that pass.
  - The event at timestamp 0 fires in the first PLAY cycle and again right after each wrap.
  - rec_toggle in PLAY: go to REC (re-record, clears buffer as in IDLE entry); pad_pulse forced 0.
- stop_all in any state: go to IDLE next cycle, pad_pulse=0. event_count and overflow are kept for status display.
- If rec_toggle and stop_all coincide, stop_all wins.
- pad_pulse is always 0 outside PLAY.
- Storage: DEPTH x (TS_WIDTH+NUM_PADS) register or RAM. Single write port; read is combinational at idx (or registered, with latency hidden so pulse timing above holds).

Test Plan:
- Reset mid-PLAY: drive resetn=0 for 1 cycle -> next cycle playing=0, pad_pulse=0, event_count=0, overflow=0.
- Basic loop, tick every 4 cycles:
  - Stimulus: rec_toggle; press pad0 (8'h01) at timer=2; press pad1 (8'h02) at timer=5; rec_toggle at timer=7.
  - Response: event_count=2, loop_len=8, playing=1. pad_pulse=8'h01 during timer=2, 8'h02 during timer=5, repeating every 32 cycles for 3 loops.
- Simultaneous press and coincidence: pad0 and pad2 rise in the same cycle -> one event 8'h05. A second press within the same tick -> two events with equal ts, pulsed on consecutive cycles.
- Overflow: 33 distinct presses with DEPTH=32 -> event_count=32, overflow=1; playback contains the first 32 only.
- Empty stop / control priority:
  - rec_toggle twice with no presses -> back to IDLE, playing=0.
  - rec_toggle with stop_all in the same cycle -> IDLE.
  - rec_toggle in PLAY -> REC with event_count=0.
- Saturation: TS_WIDTH=4, tick every cycle, no stop -> auto-transition to PLAY at timer=15, loop_len=16.
